// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch-state encoding and PC constants
//   fetch_state_t : REQ / WAIT / HOLD encoding of the fetch FSM
//   PC_W          : PC, address and instruction word width
//   PC_STEP       : default sequential PC increment (word-addressed memory)
//   RESET_PC      : PC value after reset, matching ProgramCounter
package cpu_pkg;
    localparam int PC_W    = 16;
    localparam int PC_STEP = 1;
    localparam logic [PC_W-1:0] RESET_PC = 16'h0000;
    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;
endpackage

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end for an enable-less ProgramCounter
//   clk, reset                       : clock, asynchronous active-high reset
//   pc_cur / pc_next                 : ProgramCounter pc_out / pc_in (pc_next combinational)
//   imem_req_valid/ready/addr        : single outstanding instruction-memory request
//   imem_resp_valid/data             : one response per accepted request
//   inst_valid/ready/data/pc         : buffered instruction to decode
//   redirect_valid/target            : taken branch/jump pulse and new PC
//   halt                             : suppresses new requests
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int PC_W    = cpu_pkg::PC_W,
    parameter int PC_STEP = cpu_pkg::PC_STEP
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [PC_W-1:0] pc_cur,
    output logic [PC_W-1:0] pc_next,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [PC_W-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [PC_W-1:0] imem_resp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [PC_W-1:0] inst_data,
    output logic [PC_W-1:0] inst_pc,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_target,
    input  logic            halt
);
    fetch_state_t    r_state, w_state_d;
    logic            r_squash;
    logic            r_inst_valid;
    logic [PC_W-1:0] r_inst_data;
    logic [PC_W-1:0] r_inst_pc;
    logic [PC_W-1:0] r_req_addr;
    logic            w_hs;
    logic            w_accept;

    assign w_hs     = (r_state == REQ) && !halt && imem_req_ready;
    // A response is kept only if its request was not overtaken by a redirect,
    // whether the redirect came earlier (squash) or arrives with the response.
    assign w_accept = (r_state == WAIT) && imem_resp_valid && !r_squash && !redirect_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= REQ;
        else       r_state <= w_state_d;
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            REQ:     w_state_d = w_hs ? WAIT : REQ;
            WAIT:    w_state_d = !imem_resp_valid ? WAIT : (w_accept ? HOLD : REQ);
            HOLD:    w_state_d = (redirect_valid || inst_ready) ? REQ : HOLD;
            default: w_state_d = REQ;
        endcase
    end

    // The PC register loads every cycle, so holding means feeding pc_cur back.
    always_comb begin
        imem_req_valid = (r_state == REQ) && !halt;
        imem_req_addr  = pc_cur;
        pc_next        = redirect_valid ? redirect_target :
                         w_hs           ? pc_cur + PC_W'(PC_STEP) : pc_cur;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_squash     <= 1'b0;
            r_inst_valid <= 1'b0;
            r_inst_data  <= '0;
            r_inst_pc    <= RESET_PC;
            r_req_addr   <= RESET_PC;
        end else begin
            if (w_hs) r_req_addr <= pc_cur;
            if (w_hs && redirect_valid) r_squash <= 1'b1;
            else if (r_state == WAIT) r_squash <= imem_resp_valid ? 1'b0 : (r_squash || redirect_valid);
            if (w_accept) begin
                r_inst_valid <= 1'b1;
                r_inst_data  <= imem_resp_data;
                r_inst_pc    <= r_req_addr;
            end else if (r_state == HOLD && (inst_ready || redirect_valid)) begin
                r_inst_valid <= 1'b0;
            end
        end
    end

    assign inst_valid = r_inst_valid;
    assign inst_data  = r_inst_data;
    assign inst_pc    = r_inst_pc;
endmodule
